button_debounce: RTL and testbench

- Receiving end of the board's active-low push-button interface: turns raw, asynchronous, bouncing button pins into clean, synchronous, active-high pressed levels and one-cycle press/release/long-press events.
- Sits between the top-level `button_i` pins and the LED/mode logic in the main design.
- Runs on the 12 MHz board clock.
- One independent debounce channel per button.

---
 rtl/button_pkg.sv | 14 +
 rtl/button_debounce_ch.sv | 123 ++++++++++++
 rtl/button_debounce.sv | 35 +++
 tb/tb_button_debounce.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types and default timing for the push-button debounce block.
package button_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } btn_state_t;

  localparam int unsigned BTN_DEBOUNCE_1MS = 12000;
  localparam int unsigned BTN_LONG_500MS   = 6000000;

endpackage

// File: rtl/button_debounce_ch.sv
// One debounce channel: 2-flop synchroniser, press/release debounce FSM
// and hold counter producing registered level and pulse outputs.
module button_debounce_ch
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = BTN_DEBOUNCE_1MS,
  parameter int unsigned LONG_CYCLES     = BTN_LONG_500MS
) (
  input  logic clk,
  input  logic rst_ni,
  input  logic button,
  output logic pressed,
  output logic press,
  output logic rel,
  output logic long_pulse,
  output logic held
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HW = $clog2(LONG_CYCLES);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HMAX = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HPRE = HW'(LONG_CYCLES - 2);

  logic [1:0]    sync;
  logic          s;
  btn_state_t    state, state_n;
  logic [DW-1:0] dcnt, dcnt_n;
  logic [HW-1:0] hcnt, hcnt_n;
  logic          pressed_n, press_n, rel_n, long_n, held_n;

  // Pins idle high, so the synchroniser resets to the unpressed level.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) sync <= '1;
    else         sync <= {sync[0], button};
  end

  assign s = ~sync[1];

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= RELEASED;
      dcnt       <= '0;
      hcnt       <= '0;
      pressed    <= 1'b0;
      press      <= 1'b0;
      rel        <= 1'b0;
      long_pulse <= 1'b0;
      held       <= 1'b0;
    end else begin
      state      <= state_n;
      dcnt       <= dcnt_n;
      hcnt       <= hcnt_n;
      pressed    <= pressed_n;
      press      <= press_n;
      rel        <= rel_n;
      long_pulse <= long_n;
      held       <= held_n;
    end
  end

  always_comb begin
    state_n   = state;
    dcnt_n    = dcnt;
    hcnt_n    = hcnt;
    pressed_n = pressed;
    press_n   = 1'b0;
    rel_n     = 1'b0;
    long_n    = 1'b0;
    held_n    = held;

    // Hold time keeps running through a release debounce; saturation
    // guarantees the long pulse fires only once per press.
    if (state == PRESSED || state == RELEASE_WAIT) begin
      if (hcnt != HMAX) hcnt_n = hcnt + 1'b1;
      if (hcnt == HPRE) begin
        long_n = 1'b1;
        held_n = 1'b1;
      end
    end

    case (state)
      RELEASED: begin
        if (s) begin
          state_n = PRESS_WAIT;
          dcnt_n  = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_n = RELEASED;
        end else if (dcnt == DMAX) begin
          state_n   = PRESSED;
          pressed_n = 1'b1;
          press_n   = 1'b1;
          hcnt_n    = '0;
        end else begin
          dcnt_n = dcnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_n = RELEASE_WAIT;
          dcnt_n  = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_n = PRESSED;
        end else if (dcnt == DMAX) begin
          state_n   = RELEASED;
          pressed_n = 1'b0;
          held_n    = 1'b0;
          rel_n     = 1'b1;
        end else begin
          dcnt_n = dcnt + 1'b1;
        end
      end
      default: state_n = RELEASED;
    endcase
  end

endmodule

// File: rtl/button_debounce.sv
// Active-low push-button receiver: one independent debounce channel per pin.
module button_debounce
  import button_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS     = 3,
  parameter int unsigned DEBOUNCE_CYCLES = BTN_DEBOUNCE_1MS,
  parameter int unsigned LONG_CYCLES     = BTN_LONG_500MS
) (
  input  logic                   clk,
  input  logic                   rst_ni,
  input  logic [NUM_BUTTONS-1:0] button_i,
  output logic [NUM_BUTTONS-1:0] pressed_o,
  output logic [NUM_BUTTONS-1:0] press_o,
  output logic [NUM_BUTTONS-1:0] release_o,
  output logic [NUM_BUTTONS-1:0] long_o,
  output logic [NUM_BUTTONS-1:0] held_o
);

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
    button_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES)
    ) u_ch (
      .clk        (clk),
      .rst_ni     (rst_ni),
      .button     (button_i[i]),
      .pressed    (pressed_o[i]),
      .press      (press_o[i]),
      .rel        (release_o[i]),
      .long_pulse (long_o[i]),
      .held       (held_o[i])
    );
  end

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce with DEBOUNCE_CYCLES=8, LONG_CYCLES=32.
`timescale 1ns/1ps
module tb_button_debounce;

  localparam int unsigned LAT = 10;   // debounce 8 + 2 synchroniser edges
  localparam int unsigned LNG = 31;   // long pulse edges after press pulse

  typedef struct {
    int unsigned cyc;
    logic [2:0]  press;
    logic [2:0]  rel;
    logic [2:0]  lng;
  } ev_t;

  logic       clk;
  logic       rst_n;
  logic [2:0] button;
  logic [2:0] pressed_o, press_o, release_o, long_o, held_o;

  int unsigned cyc;
  int          checks;
  int          errors;
  ev_t         exp_q[$];
  ev_t         ev;
  int unsigned e0, e1;

  button_debounce #(
    .NUM_BUTTONS     (3),
    .DEBOUNCE_CYCLES (8),
    .LONG_CYCLES     (32)
  ) dut (
    .clk       (clk),
    .rst_ni    (rst_n),
    .button_i  (button),
    .pressed_o (pressed_o),
    .press_o   (press_o),
    .release_o (release_o),
    .long_o    (long_o),
    .held_o    (held_o)
  );

  initial clk = 1'b0;
  always #41.6665 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every pulse cycle must match the oldest expected event.
  always @(negedge clk) begin
    if (rst_n) begin
      if ((press_o | release_o | long_o) != 3'b000) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse cyc=%0d press=%b release=%b long=%b, required no pulse",
                   cyc, press_o, release_o, long_o);
        end else begin
          ev = exp_q.pop_front();
          if (ev.cyc != cyc || ev.press !== press_o || ev.rel !== release_o || ev.lng !== long_o) begin
            errors++;
            $display("FAIL pulse got cyc=%0d press=%b release=%b long=%b, required cyc=%0d press=%b release=%b long=%b",
                     cyc, press_o, release_o, long_o, ev.cyc, ev.press, ev.rel, ev.lng);
          end
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
        checks++;
        errors++;
        ev = exp_q.pop_front();
        $display("FAIL missing_pulse at cyc=%0d: got none, required press=%b release=%b long=%b",
                 ev.cyc, ev.press, ev.rel, ev.lng);
      end
    end
  end

  task automatic push(input int unsigned c, input logic [2:0] p, input logic [2:0] r,
                      input logic [2:0] l);
    ev_t e;
    e.cyc = c; e.press = p; e.rel = r; e.lng = l;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  // Drive pins at a falling edge; returns E0, the rising edge that samples them.
  task automatic drive(input logic [2:0] v, output int unsigned edge0);
    @(negedge clk);
    button = v;
    edge0  = cyc + 1;
  endtask

  task automatic wait_cyc(input int unsigned n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pressed"}, pressed_o, 3'b000);
    chk({tag, "_press"},   press_o,   3'b000);
    chk({tag, "_release"}, release_o, 3'b000);
    chk({tag, "_long"},    long_o,    3'b000);
    chk({tag, "_held"},    held_o,    3'b000);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    button = 3'b000;

    // 1: reset with pins low, then a fresh press out of reset
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    e0 = cyc + 1;
    push(e0 + LAT, 3'b111, 3'b000, 3'b000);
    wait_cyc(e0 + LAT + 2);
    chk("s1_pressed", pressed_o, 3'b111);
    drive(3'b111, e1);
    push(e1 + LAT, 3'b000, 3'b111, 3'b000);
    wait_cyc(e1 + LAT + 2);
    chk("s1_released", pressed_o, 3'b000);

    // 2: clean press/release on bit 0
    drive(3'b110, e0);
    push(e0 + LAT, 3'b001, 3'b000, 3'b000);
    wait_cyc(e0 + LAT + 1);
    chk("s2_pressed", pressed_o, 3'b001);
    chk("s2_held", held_o, 3'b000);
    wait_cyc(e0 + 19);
    drive(3'b111, e1);
    push(e1 + LAT, 3'b000, 3'b001, 3'b000);
    wait_cyc(e1 + LAT - 1);
    chk("s2_still_pressed", pressed_o, 3'b001);
    wait_cyc(e1 + LAT + 1);
    chk("s2_released", pressed_o, 3'b000);

    // 3: bit 1 bouncing every 3 clocks never gets accepted
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i % 3 == 0) button[1] = ~button[1];
      if (i % 3 == 2) chk("s3_bounce_pressed", pressed_o, 3'b000);
    end
    button = 3'b111;
    repeat (15) @(negedge clk);
    chk("s3_final_pressed", pressed_o, 3'b000);

    // 4: long press on bit 2
    drive(3'b011, e0);
    push(e0 + LAT, 3'b100, 3'b000, 3'b000);
    push(e0 + LAT + LNG, 3'b000, 3'b000, 3'b100);
    wait_cyc(e0 + 30);
    chk("s4_pressed", pressed_o, 3'b100);
    chk("s4_held_before_long", held_o, 3'b000);
    wait_cyc(e0 + LAT + LNG + 1);
    chk("s4_held_after_long", held_o, 3'b100);
    wait_cyc(e0 + 59);
    drive(3'b111, e1);
    push(e1 + LAT, 3'b000, 3'b100, 3'b000);
    wait_cyc(e1 + LAT - 1);
    chk("s4_held_until_release", held_o, 3'b100);
    wait_cyc(e1 + LAT + 1);
    chk("s4_held_cleared", held_o, 3'b000);
    chk("s4_released", pressed_o, 3'b000);

    // 5: 4-clock release glitch on bit 0 is absorbed
    drive(3'b110, e0);
    push(e0 + LAT, 3'b001, 3'b000, 3'b000);
    wait_cyc(e0 + 14);
    drive(3'b111, e1);
    repeat (3) @(negedge clk);
    drive(3'b110, e1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("s5_glitch_pressed", pressed_o, 3'b001);
    end
    drive(3'b111, e1);
    push(e1 + LAT, 3'b000, 3'b001, 3'b000);
    wait_cyc(e1 + LAT + 1);
    chk("s5_released", pressed_o, 3'b000);

    // 6: simultaneous press, async reset mid-hold, fresh press afterwards
    drive(3'b000, e0);
    push(e0 + LAT, 3'b111, 3'b000, 3'b000);
    wait_cyc(e0 + 15);
    chk("s6_pressed", pressed_o, 3'b111);
    #10 rst_n = 1'b0;
    #1 chk_all_zero("s6_async_reset");
    repeat (2) @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    e0 = cyc + 1;
    push(e0 + LAT, 3'b111, 3'b000, 3'b000);
    wait_cyc(e0 + LAT + 2);
    chk("s6_repressed", pressed_o, 3'b111);
    drive(3'b111, e1);
    push(e1 + LAT, 3'b000, 3'b111, 3'b000);
    wait_cyc(e1 + LAT + 2);
    chk("s6_released", pressed_o, 3'b000);

    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending events, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
